mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_ctrl_pkg.sv | 15 +
 rtl/mult_op_order.sv | 20 ++
 rtl/mult_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_mult_seq_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared constants for the sequential shift-free multiplier controller.
// State encodings are plain localparams so legacy tools can consume them.
package mult_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LOAD_A = 3'd1;
    localparam state_t LOAD_B = 3'd2;
    localparam state_t ACCUM  = 3'd3;
    localparam state_t DONE   = 3'd4;

endpackage

// File: rtl/mult_op_order.sv
// Combinational operand ordering: larger operand to a, smaller to b, so the
// repeated-addition loop runs for the smaller count.
module mult_op_order
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    logic swap;

    assign swap = (op_b > op_a);
    assign a    = swap ? op_b : op_a;
    assign b    = swap ? op_a : op_b;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control FSM for a repeated-addition multiplier datapath (P <= P + A, B--).
// Optional iteration limit enabled by defining MULT_TIMEOUT_EN.
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned MAX_ITER = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] data_out,
    output logic             ld_a,
    output logic             ld_b,
    output logic             ld_p,
    output logic             clr_p,
    output logic             dec_b,
    input  logic             eqz,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] iter
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] iter_q, iter_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ord_a, ord_b;
    logic             limit_hit;

    mult_op_order #(
        .WIDTH (WIDTH)
    ) u_op_order (
        .op_a (op_a),
        .op_b (op_b),
        .a    (ord_a),
        .b    (ord_b)
    );

`ifdef MULT_TIMEOUT_EN
    localparam logic [WIDTH-1:0] MAX_ITER_W = WIDTH'(MAX_ITER);
    assign limit_hit = (iter_q >= MAX_ITER_W);
`else
    logic unused_max_iter;
    assign unused_max_iter = |MAX_ITER;
    assign limit_hit       = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        iter_d   = iter_q;
        err_d    = err_q;
        data_out = '0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        ld_p     = 1'b0;
        clr_p    = 1'b0;
        dec_b    = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    a_d     = ord_a;
                    b_d     = ord_b;
                    iter_d  = '0;
                    err_d   = 1'b0;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                data_out = a_q;
                ld_a     = 1'b1;
                state_d  = LOAD_B;
            end
            LOAD_B: begin
                data_out = b_q;
                ld_b     = 1'b1;
                clr_p    = 1'b1;
                state_d  = ACCUM;
            end
            ACCUM: begin
                if (eqz) begin
                    state_d = DONE;
                end else if (limit_hit) begin
                    // Abandon the loop without a further strobe and flag it.
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ld_p  = 1'b1;
                    dec_b = 1'b1;
                    if (iter_q != '1) begin
                        iter_d = iter_q + WIDTH'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign err  = done & err_q;
    assign iter = iter_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl paired with a repeated-addition datapath model.
// Build with MULT_TIMEOUT_EN defined to exercise the iteration limit.
module tb_mult_seq_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] data_out;
    logic             ld_a, ld_b, ld_p, clr_p, dec_b;
    logic             eqz;
    logic             busy, done, err;
    logic [WIDTH-1:0] iter;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(
        .WIDTH    (WIDTH),
        .MAX_ITER (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op_a     (op_a),
        .op_b     (op_b),
        .data_out (data_out),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .ld_p     (ld_p),
        .clr_p    (clr_p),
        .dec_b    (dec_b),
        .eqz      (eqz),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .iter     (iter)
    );

    // Repeated-addition datapath model.
    logic [WIDTH-1:0] dp_a = '0;
    logic [WIDTH-1:0] dp_b = '0;
    logic [31:0]      dp_p = '0;

    always @(posedge clk) begin
        if (ld_a) dp_a <= data_out;
        if (ld_b) dp_b <= data_out;
        else if (dec_b) dp_b <= dp_b - 1'b1;
        if (clr_p) dp_p <= '0;
        else if (ld_p) dp_p <= dp_p + 32'(dp_a);
    end

    assign eqz = (dp_b == '0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue(input int a, input int b);
        @(negedge clk);
        req  = 1'b1;
        op_a = WIDTH'(a);
        op_b = WIDTH'(b);
        @(posedge clk);
    endtask

    // Called just after the accepting edge; returns at the negedge where done is high.
    task automatic finish_op(input string tag, input int exp_a, input int exp_b,
                             input int exp_p, input int exp_lat, input int exp_pulses,
                             input int exp_iter, input int exp_err, input bit drop_req);
        int lat     = 0;
        int pulses  = 0;
        bit seen    = 1'b0;
        bit excl_ok = 1'b1;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge clk);
            if (ld_p) pulses++;
            if ((int'(ld_a) + int'(ld_b) + int'(ld_p)) > 1 || ld_p != dec_b ||
                (data_out != '0 && !ld_a && !ld_b)) excl_ok = 1'b0;
            if (c == 1) begin
                check({tag, "_lda_data"}, data_out, exp_a);
                check({tag, "_lda"}, ld_a, 1);
            end
            if (c == 2) begin
                check({tag, "_ldb_data"}, data_out, exp_b);
                check({tag, "_ldb_clr"}, {ld_b, clr_p}, 2'b11);
            end
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end
            if (c == 1 && drop_req) begin
                req  = 1'b0;
                op_a = '1;
                op_b = '1;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_product"}, dp_p, exp_p);
        check({tag, "_iter"}, iter, exp_iter);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_busy_at_done"}, busy, 1);
        check({tag, "_exclusive"}, excl_ok, 1);
    endtask

    initial begin
        bit abort_done;
        rst  = 1'b1;
        req  = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_strobes", {ld_a, ld_b, ld_p, clr_p, dec_b}, 0);
        check("rst_data_out", data_out, 0);
        check("rst_iter", iter, 0);
        rst = 1'b0;

        issue(17, 5);
        finish_op("m17x5", 17, 5, 85, 9, 5, 5, 0, 1'b1);

        issue(3, 200);
        finish_op("m3x200", 200, 3, 600, 7, 3, 3, 0, 1'b1);
        @(negedge clk);
        check("m3x200_done_pulse", done, 0);
        check("m3x200_iter_hold", iter, 3);

        issue(0, 9);
        finish_op("m0x9", 9, 0, 0, 4, 0, 0, 0, 1'b1);

        // Abort 17*5 on its third ACCUM cycle.
        issue(17, 5);
        abort_done = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (done) abort_done = 1'b1;
            req = 1'b0;
        end
        @(negedge clk);
        check("abort_in_accum", ld_p, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        if (done) abort_done = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_outputs", {ld_a, ld_b, ld_p, clr_p, dec_b, done, err}, 0);
        check("abort_data_iter", {data_out, iter}, 0);
        @(negedge clk);
        if (done) abort_done = 1'b1;
        check("abort_no_done", abort_done, 0);

        issue(6, 7);
        finish_op("m6x7", 7, 6, 42, 10, 6, 6, 0, 1'b1);

        // req held across done: second request accepted after one IDLE cycle.
        issue(4, 4);
        finish_op("b2b_4x4", 4, 4, 16, 8, 4, 4, 0, 1'b0);
        op_a = 16'd2;
        op_b = 16'd3;
        @(negedge clk);
        check("b2b_idle_gap", busy, 0);
        @(posedge clk);
        finish_op("b2b_2x3", 3, 2, 6, 6, 2, 2, 0, 1'b1);

`ifdef MULT_TIMEOUT_EN
        issue(50, 50);
        finish_op("timeout", 50, 50, 500, 14, 10, 10, 1, 1'b1);
`else
        issue(50, 50);
        finish_op("m50x50", 50, 50, 2500, 54, 50, 50, 0, 1'b1);
`endif
        @(negedge clk);
        check("final_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
